// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS32 pipeline: performs loads/stores over a
// req/gnt/rvalid data bus and emits a registered write-back record or exception pulse.
module mem_stage #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_waddr,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        wb_valid,
  output logic        wb_wreg,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        exc_align,
  output logic        exc_buserr,
  output logic [31:0] exc_addr
);

  localparam int unsigned DATA_W = 32;
  localparam logic [7:0]  CNT_LAST = 8'(BUS_TIMEOUT - 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  function automatic logic is_mem(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
    logic half_op;
    logic word_op;
    half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word_op = (op == OP_LW) || (op == OP_SW);
    return (half_op && lane[0]) || (word_op && (lane != 2'b00));
  endfunction

  function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      OP_LB, OP_LBU, OP_SB: be = 4'b0001 << lane;
      OP_LH, OP_LHU, OP_SH: be = lane[1] ? 4'b1100 : 4'b0011;
      default:              be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating narrow stores across all lanes lets the bus pick any lane via be.
  function automatic logic [DATA_W-1:0] store_lanes(input logic [3:0] op,
                                                    input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    case (op)
      OP_SB:   w = {4{d[7:0]}};
      OP_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [3:0] op,
                                                     input logic [1:0] lane,
                                                     input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [DATA_W-1:0] v;
    shifted = rdata >> {lane, 3'b000};
    b_s     = shifted[7:0];
    h_s     = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   v = DATA_W'(b_s);
      OP_LBU:  v = {24'd0, shifted[7:0]};
      OP_LH:   v = DATA_W'(h_s);
      OP_LHU:  v = {16'd0, lane[1] ? rdata[31:16] : rdata[15:0]};
      default: v = rdata;
    endcase
    return v;
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              wreg_q, wreg_d;
  logic [4:0]        waddr_q, waddr_d;

  logic              dbus_req_q, dbus_req_d;
  logic              dbus_we_q, dbus_we_d;
  logic [DATA_W-1:0] dbus_addr_q, dbus_addr_d;
  logic [3:0]        dbus_be_q, dbus_be_d;
  logic [DATA_W-1:0] dbus_wdata_q, dbus_wdata_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_wreg_q, wb_wreg_d;
  logic [4:0]        wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic              exc_align_q, exc_align_d;
  logic              exc_buserr_q, exc_buserr_d;
  logic [DATA_W-1:0] exc_addr_q, exc_addr_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wreg_d       = wreg_q;
    waddr_d      = waddr_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_be_d    = dbus_be_q;
    dbus_wdata_d = dbus_wdata_q;
    wb_valid_d   = 1'b0;
    wb_wreg_d    = wb_wreg_q;
    wb_waddr_d   = wb_waddr_q;
    wb_wdata_d   = wb_wdata_q;
    exc_align_d  = 1'b0;
    exc_buserr_d = 1'b0;
    exc_addr_d   = exc_addr_q;

    case (state_q)
      S_IDLE: begin
        // Late rvalid after an abort lands here and is deliberately dropped.
        if (ex_valid) begin
          if (!is_mem(ex_memop)) begin
            wb_valid_d = 1'b1;
            wb_wreg_d  = ex_wreg;
            wb_waddr_d = ex_waddr;
            wb_wdata_d = ex_result;
          end else if (misaligned(ex_memop, ex_result[1:0])) begin
            exc_align_d = 1'b1;
            exc_addr_d  = ex_result;
          end else begin
            state_d      = S_REQ;
            cnt_d        = 8'd0;
            op_d         = ex_memop;
            addr_d       = ex_result;
            wreg_d       = ex_wreg;
            waddr_d      = ex_waddr;
            dbus_req_d   = 1'b1;
            dbus_we_d    = is_store(ex_memop);
            dbus_addr_d  = {ex_result[31:2], 2'b00};
            dbus_be_d    = byte_en(ex_memop, ex_result[1:0]);
            dbus_wdata_d = store_lanes(ex_memop, ex_store_data);
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (dbus_gnt) begin
          dbus_req_d = 1'b0;
          if (is_store(op_q)) begin
            state_d    = S_IDLE;
            wb_valid_d = 1'b1;
            wb_wreg_d  = 1'b0;
            wb_waddr_d = waddr_q;
          end else begin
            state_d = S_WAIT;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_IDLE;
          dbus_req_d   = 1'b0;
          exc_buserr_d = 1'b1;
          exc_addr_d   = addr_q;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (dbus_rvalid) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_wreg_d  = wreg_q;
          wb_waddr_d = waddr_q;
          wb_wdata_d = load_extract(op_q, addr_q[1:0], dbus_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_IDLE;
          exc_buserr_d = 1'b1;
          exc_addr_d   = addr_q;
        end
      end

      default: begin
        state_d    = S_IDLE;
        dbus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      op_q         <= 4'd0;
      addr_q       <= '0;
      wreg_q       <= 1'b0;
      waddr_q      <= 5'd0;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_be_q    <= 4'd0;
      dbus_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_wreg_q    <= 1'b0;
      wb_waddr_q   <= 5'd0;
      wb_wdata_q   <= '0;
      exc_align_q  <= 1'b0;
      exc_buserr_q <= 1'b0;
      exc_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wreg_q       <= wreg_d;
      waddr_q      <= waddr_d;
      dbus_req_q   <= dbus_req_d;
      dbus_we_q    <= dbus_we_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_be_q    <= dbus_be_d;
      dbus_wdata_q <= dbus_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_wreg_q    <= wb_wreg_d;
      wb_waddr_q   <= wb_waddr_d;
      wb_wdata_q   <= wb_wdata_d;
      exc_align_q  <= exc_align_d;
      exc_buserr_q <= exc_buserr_d;
      exc_addr_q   <= exc_addr_d;
    end
  end

  assign ex_ready   = (state_q == S_IDLE);
  assign dbus_req   = dbus_req_q;
  assign dbus_we    = dbus_we_q;
  assign dbus_addr  = dbus_addr_q;
  assign dbus_be    = dbus_be_q;
  assign dbus_wdata = dbus_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_wreg    = wb_wreg_q;
  assign wb_waddr   = wb_waddr_q;
  assign wb_wdata   = wb_wdata_q;
  assign exc_align  = exc_align_q;
  assign exc_buserr = exc_buserr_q;
  assign exc_addr   = exc_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-addressed memory model predicts every
// write-back/exception record and bus transfer; a bus responder and a monitor check them.
module tb_mem_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_memop;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic        ex_wreg;
  logic [4:0]  ex_waddr;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        wb_valid;
  logic        wb_wreg;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        exc_align;
  logic        exc_buserr;
  logic [31:0] exc_addr;

  always #5 clk = ~clk;

  mem_stage #(.BUS_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_memop(ex_memop),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .exc_align(exc_align), .exc_buserr(exc_buserr), .exc_addr(exc_addr)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [256];

  typedef struct {
    int          kind;       // 0 write-back, 1 alignment exc, 2 bus timeout exc
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] data;
    bit          chk_data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gw;
    int          rw;
  } plan_t;
  plan_t plan_q[$];
  bit resp_busy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!(ex_ready === 1'b1 && !resp_busy) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("wait_ready_bound", 32'd0, 32'd1);
  endtask

  // gw: REQ cycles the responder lets pass before granting; rw: WAIT cycles before rvalid.
  task automatic issue(input logic [3:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic wr, input logic [4:0] wa, input int gw, input int rw,
                       input bit expect_it);
    int sz, c, lane;
    bit tout;
    logic [7:0] bi;
    logic [31:0] raw;
    plan_t p;
    exp_t e;
    wait_idle();
    sz = op_size(op);
    c = cyc;
    lane = int'(res[1:0]);
    ex_valid = 1'b1; ex_memop = op; ex_result = res; ex_store_data = sd;
    ex_wreg = wr; ex_waddr = wa;
    e.kind = 0; e.wreg = wr; e.waddr = wa; e.data = res; e.chk_data = 1; e.cyc = c + 1;
    if (sz != 0) begin
      if ((lane % sz) != 0) begin
        e.kind = 1;
      end else begin
        p.we = (op >= 4'd6);
        p.addr = {res[31:2], 2'b00};
        p.be = 4'd0;
        for (int k = 0; k < sz; k++) p.be[lane + k] = 1'b1;
        for (int k = 0; k < 4; k++) p.wdata[8*k +: 8] = sd[8*(k % sz) +: 8];
        for (int k = 0; k < 4; k++) begin
          bi = {res[7:2], 2'b00} + 8'(k);
          p.rdata[8*k +: 8] = mem[bi];
        end
        p.gw = gw; p.rw = rw;
        // The timeout is checked only in the T-th cycle of the transfer.
        tout = (gw + 1 > T) || (!p.we && (gw + 1 < T) && (gw + rw + 2 > T));
        if (tout) begin
          e.kind = 2; e.cyc = c + T + 1;
        end else if (p.we) begin
          e.wreg = 1'b0; e.chk_data = 0; e.cyc = c + gw + 2;
          for (int k = 0; k < sz; k++) begin
            bi = res[7:0] + 8'(k);
            mem[bi] = sd[8*k +: 8];
          end
        end else begin
          raw = 32'd0;
          for (int k = 0; k < sz; k++) begin
            bi = res[7:0] + 8'(k);
            raw[8*k +: 8] = mem[bi];
          end
          case (op)
            4'd1:    e.data = 32'($signed(raw[7:0]));
            4'd3:    e.data = 32'($signed(raw[15:0]));
            default: e.data = raw;
          endcase
          e.cyc = c + gw + rw + 3;
        end
        plan_q.push_back(p);
        resp_busy = 1;
      end
    end
    if (expect_it) exp_q.push_back(e);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_memop = 4'($urandom); ex_result = $urandom;
  endtask

  // Bus responder: checks each REQ cycle against the planned transfer and answers it.
  initial begin : responder
    plan_t cur;
    bit act = 0;
    int ph = 0;
    int cnt = 0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = $urandom;
      if (!act && plan_q.size() > 0 && dbus_req === 1'b1) begin
        cur = plan_q.pop_front();
        act = 1; ph = 0; cnt = 0;
      end
      if (act) begin
        if (ph == 0) begin
          if (dbus_req !== 1'b1) begin
            act = 0; resp_busy = 0;
          end else begin
            cnt++;
            chk("bus_we", {31'd0, dbus_we}, {31'd0, cur.we});
            chk("bus_addr", dbus_addr, cur.addr);
            chk("bus_be", {28'd0, dbus_be}, {28'd0, cur.be});
            if (cur.we) chk("bus_wdata", dbus_wdata, cur.wdata);
            if (cnt == cur.gw + 1) begin
              dbus_gnt = 1'b1;
              if (cur.we) begin act = 0; resp_busy = 0; end
              else begin ph = 1; cnt = 0; end
            end
          end
        end else begin
          chk("req_low_in_wait", {31'd0, dbus_req}, 32'd0);
          cnt++;
          if (cnt == cur.rw + 1) begin
            dbus_rvalid = 1'b1; dbus_rdata = cur.rdata;
            act = 0; resp_busy = 0;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a record or exception pulse appears.
  initial begin : monitor
    exp_t e;
    logic [2:0] ev, want;
    forever begin
      @(negedge clk);
      ev = {wb_valid, exc_align, exc_buserr};
      if (ev !== 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {29'd0, ev}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          want = (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001;
          chk("event_kind", {29'd0, ev}, {29'd0, want});
          chk("event_cycle", cyc, e.cyc);
          chk("ready_at_retire", {31'd0, ex_ready}, 32'd1);
          if (e.kind == 0) begin
            chk("wb_wreg", {31'd0, wb_wreg}, {31'd0, e.wreg});
            if (e.chk_data) begin
              chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, e.waddr});
              chk("wb_wdata", wb_wdata, e.data);
            end
          end else begin
            chk("exc_addr", exc_addr, e.data);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
    chk({tag, "_req"}, {31'd0, dbus_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, dbus_we}, 32'd0);
    chk({tag, "_addr"}, dbus_addr, 32'd0);
    chk({tag, "_be"}, {28'd0, dbus_be}, 32'd0);
    chk({tag, "_wdata"}, dbus_wdata, 32'd0);
    chk({tag, "_wb"}, {26'd0, wb_valid, wb_wreg, wb_waddr}, 32'd0);
    chk({tag, "_wbdata"}, wb_wdata, 32'd0);
    chk({tag, "_exc"}, {30'd0, exc_align, exc_buserr}, 32'd0);
    chk({tag, "_excaddr"}, exc_addr, 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [3:0] op;
    rst = 1'b1; ex_valid = 1'b0; ex_memop = 4'd0; ex_result = 32'd0;
    ex_store_data = 32'd0; ex_wreg = 1'b0; ex_waddr = 5'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset");

    // Pass-through ops, back to back.
    issue(4'd0, 32'h1234_5678, 32'd0, 1'b1, 5'd5, 0, 0, 1);
    for (int i = 0; i < 3; i++) issue(4'd0, $urandom, 32'd0, 1'($urandom), 5'($urandom), 0, 0, 1);

    // lb / lbu at 0x1003 with word 0x80AA_BBCC.
    mem[8'h00] = 8'hCC; mem[8'h01] = 8'hBB; mem[8'h02] = 8'hAA; mem[8'h03] = 8'h80;
    issue(4'd1, 32'h0000_1003, 32'd0, 1'b1, 5'd7, 0, 1, 1);
    issue(4'd2, 32'h0000_1003, 32'd0, 1'b1, 5'd8, 0, 1, 1);

    // sh at 0x2002 with grant withheld for 3 cycles, then reading it back.
    issue(4'd7, 32'h0000_2002, 32'hDEAD_BEEF, 1'b1, 5'd9, 3, 0, 1);
    issue(4'd4, 32'h0000_2002, 32'd0, 1'b1, 5'd10, 1, 0, 1);

    // Misaligned lw, then the timeout corner cases.
    issue(4'd5, 32'h0000_3002, 32'd0, 1'b1, 5'd3, 0, 0, 1);
    issue(4'd5, 32'h0000_4000, 32'd0, 1'b1, 5'd3, 20, 0, 1);
    issue(4'd5, 32'h0000_4004, 32'd0, 1'b1, 5'd3, 3, 0, 1);
    issue(4'd5, 32'h0000_4008, 32'd0, 1'b1, 5'd3, 0, 5, 1);

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      issue(op, $urandom, $urandom, 1'($urandom), 5'($urandom),
            $urandom_range(0, 5), $urandom_range(0, 5), 1);
    end

    // Reset while waiting for load data; the later rvalid must be ignored.
    issue(4'd5, 32'h0000_0010, 32'd0, 1'b1, 5'd4, 0, 4, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("rst_wait");
    wait_idle();

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("plans_consumed", plan_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
